aes_key_expand: RTL and testbench

- Iterative AES-128 key schedule that produces round keys 0..10, one per handshake, for the AddRoundKey stage.
- AddRoundKey feeds the subByte stage, so this block is the key-side producer directly upstream of the round datapath.
- SubWord reuses the team's synchronous S-box, one-cycle registered read, four instances.

---
 rtl/aes_key_expand.sv | 162 ++++++++++++++++
 tb/tb_aes_key_expand.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per valid/ready beat.
// SubWord is computed by four synchronous S-boxes with a registered read.
module aes_sbox (
  input  logic       clk,
  input  logic [7:0] a,
  output logic [7:0] q
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] x,
    input int         n
  );
    return (x << n) | (x >> (8 - n));
  endfunction

  logic [7:0] b;
  logic [7:0] s;

  always_comb begin
    b = gf_inv(a);
    s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  end

  always_ff @(posedge clk) begin
    q <= s;
  end

endmodule

module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    SUB,
    MIX
  } state_t;

  state_t      state;
  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot;
  logic [31:0] sub_w;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon_nx;

  assign w0  = rk[127:96];
  assign w1  = rk[95:64];
  assign w2  = rk[63:32];
  assign w3  = rk[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  // rk is stable through SUB, so the S-box output is still valid in MIX
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .clk (clk),
      .a   (rot[8*g +: 8]),
      .q   (sub_w[8*g +: 8])
    );
  end

  always_comb begin
    t       = sub_w ^ {rcon, 24'h0};
    n0      = w0 ^ t;
    n1      = w1 ^ n0;
    n2      = w2 ^ n1;
    n3      = w3 ^ n2;
    rcon_nx = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rk       <= '0;
      rk_round <= '0;
      rcon     <= 8'h01;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rk       <= key;
            rk_round <= '0;
            rcon     <= 8'h01;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= PRESENT;
          end
        end
        PRESENT: begin
          if (rk_ready) begin
            rk_valid <= 1'b0;
            if (rk_round == 4'(NR)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= SUB;
            end
          end
        end
        SUB: begin
          state <= MIX;
        end
        MIX: begin
          rk       <= {n0, n1, n2, n3};
          rk_round <= rk_round + 4'd1;
          rcon     <= rcon_nx;
          rk_valid <= 1'b1;
          state    <= PRESENT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand against an exp/log-table key schedule.
// Covers FIPS-197 vectors, backpressure, ignored start, abort and restart.
module tb_aes_key_expand;

  localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KB   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [127:0] key;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  aes_key_expand dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .key      (key),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk       (rk),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] rkey;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] acc [0:10];
  int           checks;
  int           errors;
  int           done_cnt;
  int           gexp [0:255];
  int           glog [0:255];

  task automatic check(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] v;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    v = (x == 0) ? 8'h00 : 8'(gexp[(255 - glog[x]) % 255]);
    for (int i = 0; i < 8; i++)
      s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8]
           ^ v[(i+7)%8] ^ c[i];
    return s;
  endfunction

  task automatic push_schedule(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {ref_sbox(tmp[31:24]), ref_sbox(tmp[23:16]),
               ref_sbox(tmp[15:8]), ref_sbox(tmp[7:0])};
        tmp = tmp ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      sb.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  // a beat with valid&ready at the negedge is accepted at the next posedge
  always @(negedge clk) begin
    if (reset_n && rk_valid && rk_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rk", rk, e.rkey);
        check("sb_round", rk_round, e.rnd);
        if (rk_round <= 10) acc[rk_round] = rk;
      end
    end
    if (done) done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (!(rk_valid && rk_round == r) && n < 200) begin
      cyc(1);
      n++;
    end
    check("wait_round", n < 200, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      cyc(1);
      n++;
    end
    check("wait_done", n < 200, 1);
  endtask

  task automatic kick(input logic [127:0] k, input bit expect_go);
    start = 1'b1;
    key   = k;
    if (expect_go) push_schedule(k);
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    int n;
    int snap;
    logic [7:0] x;
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = int'(x);
      glog[x] = i;
      x = x ^ xt(x);
    end
    gexp[255] = 1;
    glog[0]   = 0;

    reset_n  = 1'b0;
    start    = 1'b0;
    key      = '0;
    rk_ready = 1'b0;
    cyc(3);
    check("rst_rk", rk, 0);
    check("rst_valid", rk_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_round", rk_round, 0);
    reset_n = 1'b1;
    cyc(1);

    // run 1: A.1 key, rk_ready high, latency checks
    rk_ready = 1'b1;
    cyc(2);
    check("idle_ready_valid", rk_valid, 0);
    check("idle_ready_busy", busy, 0);
    kick(KA, 1);
    check("r0_valid", rk_valid, 1);
    check("r0_busy", busy, 1);
    check("r0_round", rk_round, 0);
    cyc(2);
    check("sub_valid", rk_valid, 0);
    cyc(1);
    check("r1_lat_valid", rk_valid, 1);
    check("r1_lat_round", rk_round, 1);
    wait_done(n);
    check("done_latency", n + 3, 31);
    cyc(1);
    check("done_pulse", done, 0);
    check("done_count", done_cnt, 1);
    check("a_r1", acc[1], A_R1);
    check("a_r2", acc[2], A_R2);
    check("a_r10", acc[10], A_RA);
    check("a_hold_r10", rk, A_RA);
    check("a_idle_valid", rk_valid, 0);

    // run 2: backpressure on round 1, ignored start during round 4
    kick(KA, 1);
    cyc(1);
    rk_ready = 1'b0;
    wait_round(1);
    for (int i = 0; i < 7; i++) begin
      check("bp_rk", rk, A_R1);
      check("bp_round", rk_round, 1);
      check("bp_valid", rk_valid, 1);
      cyc(1);
    end
    rk_ready = 1'b1;
    cyc(1);
    check("bp_accept", rk_valid, 0);
    cyc(2);
    check("bp_r2_valid", rk_valid, 1);
    check("bp_r2_rk", rk, A_R2);
    wait_round(4);
    kick(KB, 0);
    check("ign_busy", busy, 1);
    wait_done(n);
    cyc(1);
    check("ign_r10", acc[10], A_RA);
    check("ign_sb_empty", sb.size(), 0);

    // run 3: abort in SUB after round 5 accept, then KB
    kick(KA, 1);
    wait_round(5);
    cyc(1);
    snap = done_cnt;
    reset_n = 1'b0;
    #1;
    check("abort_rk", rk, 0);
    check("abort_valid", rk_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_round", rk_round, 0);
    sb.delete();
    cyc(4);
    check("abort_no_done", done_cnt, snap);
    reset_n = 1'b1;
    cyc(1);
    kick(KB, 1);
    wait_done(n);
    cyc(1);
    check("b_r10", acc[10], B_RA);

    // run 4: back-to-back, restart in the done cycle
    kick(KA, 1);
    wait_done(n);
    kick(KA, 1);
    check("b2b_valid", rk_valid, 1);
    check("b2b_round", rk_round, 0);
    check("b2b_rk", rk, KA);
    wait_done(n);
    cyc(1);
    check("b2b_r1", acc[1], A_R1);
    check("b2b_r10", acc[10], A_RA);

    // run 5: rk_ready high through SUB and MIX has no effect
    kick(KA, 1);
    cyc(1);
    check("stray_sub_rk", rk, KA);
    check("stray_sub_round", rk_round, 0);
    cyc(1);
    check("stray_mix_valid", rk_valid, 0);
    check("stray_mix_round", rk_round, 0);
    wait_done(n);
    cyc(2);
    check("final_sb_empty", sb.size(), 0);
    check("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
